mem_responder: RTL

Memory-side responder for the multicycle CPU's data/instruction bus. It accepts one request at a time (read, word write, halfword write or byte write), performs byte/halfword stores internally as read-modify-write on a word-wide synchronous RAM, and returns a one-cycle `ready` pulse with read data or an error flag. It replaces the fixed-latency memory model and moves store merging out of the CPU datapath.

---
 rtl/mem_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU bus.
// Accepts one request at a time (read, word/halfword/byte write). Partial
// stores are done as read-modify-write on a word-wide synchronous RAM.
// Completion is a one-cycle `ready` pulse with `DataOut` and `err`.
// Byte lanes are big-endian: offset 0 is bits [31:24].
//
// Optional feature: define MEM_ALIGN_CHECK_EN to report misaligned word and
// halfword accesses as errors. Without it, misaligned accesses are
// force-aligned.
//
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   asynchronous active-high reset
//   req      in   request strobe (sampled in IDLE only)
//   wr       in   1 = write, 0 = read
//   size     in   00 word, 01 halfword, 10 byte, 11 reserved (error)
//   Address  in   byte address
//   DataIn   in   right-justified write data
//   DataOut  out  full addressed word, valid with ready
//   ready    out  one-cycle completion pulse
//   err      out  error status, valid with ready
//   busy     out  high whenever not IDLE
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t        state_q, state_d;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [AW-1:0] widx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   dout_q, dout_d;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;
  logic          ram_re;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   merged;

  logic          range_err, align_err, req_err, accept;

  assign range_err = (Address[31:2] >= 30'(DEPTH_WORDS));
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = ((size == 2'b00) && (Address[1:0] != 2'b00)) ||
                     ((size == 2'b01) && Address[0]);
`else
  assign align_err = 1'b0;
`endif
  assign req_err = range_err || (size == 2'b11) || align_err;
  assign accept  = (state_q == IDLE) && req;

  // The synchronous RAM read is launched on the accept edge so the addressed
  // word is available in ACCESS; externally this matches a read in ACCESS.
  assign ram_re = accept && !req_err;

  always_ff @(posedge Clock) begin
    if (mem_we) mem[widx_q] <= mem_wdata;
    if (ram_re) ram_q <= mem[Address[AW+1:2]];
  end

  // Lane replacement on the old word; word size never reaches MERGE.
  always_comb begin
    merged = dout_q;
    case (size_q)
      2'b01: begin
        if (off_q[1]) merged[15:0]  = wdata_q[15:0];
        else          merged[31:16] = wdata_q[15:0];
      end
      2'b10: begin
        case (off_q)
          2'd0:    merged[31:24] = wdata_q[7:0];
          2'd1:    merged[23:16] = wdata_q[7:0];
          2'd2:    merged[15:8]  = wdata_q[7:0];
          default: merged[7:0]   = wdata_q[7:0];
        endcase
      end
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_err) begin
            state_d = RESP;
            dout_d  = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!wr_q) begin
          dout_d  = ram_q;
          state_d = RESP;
        end else if (size_q == 2'b00) begin
          mem_we  = 1'b1;
          dout_d  = wdata_q;
          state_d = RESP;
        end else begin
          dout_d  = ram_q;
          state_d = MERGE;
        end
      end
      MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        dout_d    = merged;
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (accept) begin
        wr_q    <= wr;
        size_q  <= size;
        off_q   <= Address[1:0];
        widx_q  <= Address[AW+1:2];
        wdata_q <= DataIn;
        err_q   <= req_err;
      end
      dout_q <= dout_d;
    end
  end

  assign ready   = (state_q == RESP);
  assign busy    = (state_q != IDLE);
  assign err     = ready && err_q;
  assign DataOut = dout_q;

endmodule
